// File: rtl/uart_pkg.sv
// Shared UART constants and helpers: idle line level, default synchronizer
// depth and a 3-input majority function used by the input filter.
package uart_pkg;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam int   UART_SYNC_STAGES = 2;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_bit_sync.sv
// Multi-flop synchronizer for a single asynchronous bit. The chain resets to
// IDLE_LEVEL so the line looks idle immediately after reset.
module uart_bit_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_LEVEL  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour, giving a true shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_input_filter.sv
// UART rx front end: synchronizes rx_in, majority-votes three tick_16x samples
// and flags 1->0 transitions. Define UART_INPUT_FILTER_GLITCH_CNT_EN to add the
// saturating glitch_cnt output.
module uart_input_filter
  import uart_pkg::*;
#(
  parameter int   SYNC_STAGES = UART_SYNC_STAGES,
  parameter logic IDLE_LEVEL  = UART_IDLE_LEVEL
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_16x,
  input  logic       rx_in,
  output logic       rx_filtered,
  output logic       falling_edge
`ifdef UART_INPUT_FILTER_GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_cnt
`endif
);

  logic rx_sync;
  logic s0;
  logic s1;
  logic maj;

  uart_bit_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .IDLE_LEVEL  (IDLE_LEVEL)
  ) u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx_in),
    .q     (rx_sync)
  );

  // Vote over the two stored samples plus the current synchronized level.
  assign maj = maj3(s1, s0, rx_sync);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0           <= IDLE_LEVEL;
      s1           <= IDLE_LEVEL;
      rx_filtered  <= IDLE_LEVEL;
      falling_edge <= 1'b0;
    end else if (tick_16x) begin
      s1           <= s0;
      s0           <= rx_sync;
      rx_filtered  <= maj;
      falling_edge <= rx_filtered & ~maj;
    end else begin
      falling_edge <= 1'b0;
    end
  end

`ifdef UART_INPUT_FILTER_GLITCH_CNT_EN
  // Counts ticks where the raw sample disagreed with the vote; sticks at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_cnt <= 8'd0;
    end else if (tick_16x && (rx_sync != maj) && (glitch_cnt != 8'hFF)) begin
      glitch_cnt <= glitch_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_input_filter.sv
// Self-checking bench for uart_input_filter: directed scenarios plus random
// traffic, all compared against a sample-history reference model.
module tb_uart_input_filter;

  localparam int SYNC = 2;

  logic clk;
  logic rst_n;
  logic tick_16x;
  logic rx_in;
  logic rx_filtered;
  logic falling_edge;
`ifdef UART_INPUT_FILTER_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif

  uart_input_filter #(.SYNC_STAGES(SYNC), .IDLE_LEVEL(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick_16x     (tick_16x),
    .rx_in        (rx_in),
    .rx_filtered  (rx_filtered),
    .falling_edge (falling_edge)
`ifdef UART_INPUT_FILTER_GLITCH_CNT_EN
    ,
    .glitch_cnt   (glitch_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: rx_in history delays the line by SYNC edges; the last
  // two tick samples and the filtered level are kept as plain bits.
  bit m_hist[$];
  bit m_s0, m_s1, m_filt, m_fe;
  int m_gcnt;

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b1);
    m_s0 = 1'b1; m_s1 = 1'b1; m_filt = 1'b1; m_fe = 1'b0; m_gcnt = 0;
  endtask

  task automatic model_edge(input bit rx, input bit tk);
    bit sync_v, mj;
    int ones;
    sync_v = m_hist.pop_front();
    m_hist.push_back(rx);
    if (tk) begin
      ones = int'(m_s1) + int'(m_s0) + int'(sync_v);
      mj   = (ones >= 2);
      if (sync_v != mj && m_gcnt < 255) m_gcnt++;
      m_fe   = m_filt && !mj;
      m_filt = mj;
      m_s1   = m_s0;
      m_s0   = sync_v;
    end else begin
      m_fe = 1'b0;
    end
  endtask

  // One clock: drive at negedge, advance the model at posedge, compare at negedge.
  task automatic step(input bit rx, input bit tk);
    rx_in    = rx;
    tick_16x = tk;
    @(posedge clk);
    model_edge(rx, tk);
    @(negedge clk);
    check("rx_filtered", rx_filtered, m_filt);
    check("falling_edge", falling_edge, m_fe);
`ifdef UART_INPUT_FILTER_GLITCH_CNT_EN
    check("glitch_cnt", glitch_cnt, m_gcnt);
`endif
    if (falling_edge === 1'b1) fe_cnt++;
  endtask

  task automatic ticks(input bit rx, input int n, input int period);
    for (int i = 0; i < n; i++) begin
      repeat (period - 1) step(rx, 1'b0);
      step(rx, 1'b1);
    end
  endtask

  initial begin
    bit held;
    bit rnd_rx;

    rst_n = 1'b0; rx_in = 1'b1; tick_16x = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_rx_filtered", rx_filtered, 1);
    check("reset_falling_edge", falling_edge, 0);
    rst_n = 1'b1;

    // Clean fall
    fe_cnt = 0;
    ticks(1'b1, 4, 4);
    ticks(1'b0, 3, 4);
    check("clean_fall_level", rx_filtered, 0);
    check("clean_fall_pulses", fe_cnt, 1);

    // Single-clk glitch between ticks
    ticks(1'b1, 3, 16);
    fe_cnt = 0;
    repeat (7) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    repeat (7) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    ticks(1'b1, 3, 16);
    check("glitch_level", rx_filtered, 1);
    check("glitch_pulses", fe_cnt, 0);

    // Noisy fall 0,1,0,0 then two more ticks low
    fe_cnt = 0;
    ticks(1'b0, 1, 4);
    ticks(1'b1, 1, 4);
    ticks(1'b0, 2, 4);
    ticks(1'b0, 2, 4);
    check("noisy_level", rx_filtered, 0);
    check("noisy_pulses_le1", 32'(fe_cnt <= 1), 1);

    // Reset asserted mid-low, no clock edge needed
    ticks(1'b0, 2, 4);
    check("pre_reset_low", rx_filtered, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_level", rx_filtered, 1);
    check("async_reset_pulse", falling_edge, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // UART frame: idle, start 0, data 0, data 1, idle
    ticks(1'b1, 5, 16);
    fe_cnt = 0;
    ticks(1'b0, 4, 16);
    check("frame_start_pulse", fe_cnt, 1);
    ticks(1'b0, 12, 16);
    check("frame_start_level", rx_filtered, 0);
    ticks(1'b0, 16, 16);
    check("frame_d0_level", rx_filtered, 0);
    ticks(1'b1, 3, 16);
    check("frame_d1_lag3", rx_filtered, 1);
    ticks(1'b1, 13, 16);
    ticks(1'b1, 5, 16);
    check("frame_total_pulses", fe_cnt, 1);

    // Tick gating: line activity without ticks must not move the output
    held = rx_filtered;
    fe_cnt = 0;
    repeat (50) step(1'($urandom_range(0, 1)), 1'b0);
    check("gate_level", rx_filtered, held);
    check("gate_pulses", fe_cnt, 0);

    // Random traffic with bursty line and irregular (sometimes back-to-back) ticks
    rnd_rx = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) rnd_rx = ~rnd_rx;
      step(rnd_rx, 1'($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_input_filter.md
Name: uart_input_filter

Overview:
- Front-end conditioner for the UART receiver. It sits between the asynchronous rx pin and the rx state machine.
- Synchronizes rx_in into the clk domain, then rejects glitches with a 3-sample majority vote taken on each tick_16x.
- Outputs a clean level (rx_filtered) and a one-clock falling_edge pulse that the receiver uses for start-bit detection.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the rx_in synchronizer chain; legal values are 2 or more.
- IDLE_LEVEL, 1'b1, line idle level; reset value of all sample state and of rx_filtered.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- tick_16x  in  1  16x-baud oversampling strobe; one clk wide; the vote only advances when it is high.
- rx_in  in  1  raw asynchronous serial input.
- rx_filtered  out  1  synchronized, majority-filtered line level; registered.
- falling_edge  out  1  one-clk pulse when rx_filtered goes 1 to 0; registered.

Behaviour:
- Reset (asynchronous, while rst_n=0):
  - synchronizer flops, both stored vote samples and rx_filtered are forced to IDLE_LEVEL (1).
  - falling_edge is forced to 0.
  - Reset asserted mid-frame takes effect immediately, regardless of tick_16x.
- Synchronizer: rx_in is shifted through SYNC_STAGES flops on every clk; the last stage is rx_sync. It runs independently of tick_16x.
- Voting, on a clk edge with tick_16x=1:
  - maj = majority(s1, s0, rx_sync), where s0 and s1 are the two previously stored samples.
  - Shift: s1<=s0, s0<=rx_sync.
  - rx_filtered<=maj.
  - falling_edge<=rx_filtered & ~maj.
- With tick_16x=0: samples and rx_filtered hold; falling_edge<=0. falling_edge is therefore never wider than one clk.
- Latency: a clean level change on rx_in appears on rx_filtered on the 2nd tick whose sampling edge falls at least SYNC_STAGES clks after the change. Worst case is the 3rd tick after the change.
- Glitches:
  - A pulse shorter than one tick period is sampled at most once, so it never changes rx_filtered.
  - Alternating samples (0,1,0) resolve to 0 once two of the last three samples are 0.
- Exactly one falling_edge pulse per 1 to 0 transition of rx_filtered. Rising transitions produce no pulse.
- tick_16x asserted for consecutive clks is legal; each high cycle counts as one tick.

Optional Feature:
- Macro: UART_INPUT_FILTER_GLITCH_CNT_EN.
- When defined:
  - Adds output glitch_cnt [7:0].
  - On each tick where rx_sync differs from maj, the counter increments, saturating at 255.
  - Reset value is 0.
- When undefined: the port and its logic are absent. Core behaviour is identical in both cases.

Decomposition:
- Shared package uart_pkg holds:
  - UART_IDLE_LEVEL (1'b1);
  - default SYNC_STAGES constant;
  - a helper function maj3 (3-input majority).
- One sub-module, uart_bit_sync: parameterized SYNC_STAGES flop chain with asynchronous reset to IDLE_LEVEL. It is instantiated once for rx_in.

Test Plan:
- Clean fall:
  - Stimulus: rx_in=1 for 4 ticks, then rx_in=0 and 3 ticks.
  - Response: rx_filtered=0 after the 3rd tick; falling_edge high for exactly one clk in that window.
- Glitch:
  - Stimulus: rx_in=1 idle, rx_in=0 for 1 clk between ticks, then 3 ticks with rx_in=1.
  - Response: rx_filtered stays 1; falling_edge never asserts.
- Noisy fall:
  - Stimulus: across 4 ticks drive rx_in=0,1,0,0, then 2 more ticks.
  - Response: rx_filtered settles to 0; at most one falling_edge pulse.
- Reset mid-low:
  - Stimulus: rx_filtered=0 with rx_in held 0; assert rst_n=0 for 2 clks.
  - Response: rx_filtered=1 and falling_edge=0 immediately, without any tick.
- UART frame:
  - Stimulus: idle 5 ticks, start bit 0 for 16 ticks, data 0 for 16 ticks, data 1 for 16 ticks, idle.
  - Response: exactly one falling_edge within the first 4 ticks of the start bit; rx_filtered tracks each bit with lag of at most 3 ticks.
- Tick gating:
  - Stimulus: rx_in changes with tick_16x held 0 for 50 clks.
  - Response: rx_filtered unchanged; falling_edge=0.
